// File: rtl/cpinsert_pkg.sv
// Shared constants and types for the cyclic-prefix inserter (cpinsert) and its
// ping-pong sample buffer (cpbuf).
package cpinsert_pkg;

  localparam int CP_N     = 64;
  localparam int CP_LGN   = $clog2(CP_N);
  localparam int CP_CPLEN = 16;
  localparam int CP_DW    = 16;

  // One bit selects between the two frame banks.
  localparam int BANK_W = 1;
  typedef logic [BANK_W-1:0] bank_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFIX,
    S_BODY
  } rd_state_t;

endpackage

// File: rtl/cpbuf.sv
// Simple dual-port sample RAM holding both ping-pong frame banks: one write
// port and one registered read port that only advances when i_re is high.
module cpbuf #(
  parameter int DW = 16,
  parameter int AW = 7
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [2*DW-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [2*DW-1:0]   o_rdata
);

  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  // NOTE: the array has no reset so it maps onto block RAM; only the control
  // state around it is reset, and stale contents are never presented as valid.
  always_ff @(posedge i_clk) begin
    if (i_we)
      mem[i_waddr] <= i_wdata;
    if (i_re)
      o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/cpinsert.sv
// Cyclic-prefix inserter: captures IFFT frames into two banks and replays each
// as CPLEN tail samples followed by the full body. Define CPINSERT_OVERFLOW_EN
// to drop frames that arrive while the target bank is still full.
module cpinsert
  import cpinsert_pkg::*;
#(
  parameter int DW    = CP_DW,
  parameter int LGN   = CP_LGN,
  parameter int CPLEN = CP_CPLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ce,
  input  logic            i_sync,
  input  logic [2*DW-1:0] i_sample,
  input  logic            i_oce,
  output logic [2*DW-1:0] o_result,
  output logic            o_valid,
  output logic            o_sync,
  output logic            o_overflow
);

  localparam int              N        = 1 << LGN;
  localparam logic [LGN-1:0]  LAST     = LGN'(N - 1);
  localparam logic [LGN-1:0]  CP_START = LGN'(N - CPLEN);

  // Write side
  logic           wactive;
  logic [LGN-1:0] waddr;
  bank_t          wbank;
  logic [1:0]     full;
  logic           drop_frame;
  logic           wr_en;
  logic           wr_last;
  logic [LGN-1:0] wr_off;
  logic [LGN:0]   wr_addr;

`ifdef CPINSERT_OVERFLOW_EN
  assign drop_frame = i_ce && i_sync && full[wbank];
`else
  assign drop_frame = 1'b0;
`endif

  assign wr_en   = i_ce && (i_sync ? !drop_frame : wactive);
  assign wr_last = i_ce && !i_sync && wactive && (waddr == LAST);
  assign wr_off  = i_sync ? '0 : waddr;
  assign wr_addr = {wbank, wr_off};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register regardless of order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wactive <= 1'b0;
      waddr   <= '0;
      wbank   <= '0;
    end else if (i_ce) begin
      if (i_sync) begin
        // A sync always restarts the current bank; the sync sample is word 0.
        wactive <= !drop_frame;
        waddr   <= LGN'(1);
      end else if (wactive) begin
        waddr <= waddr + 1'b1;
        if (waddr == LAST) begin
          wactive <= 1'b0;
          wbank   <= ~wbank;
        end
      end
    end
  end

  // Read side. state/raddr/rbank describe the sample currently held in the
  // RAM output register; the RAM is addressed with the next position so the
  // output register can pick the sample up on the following strobe.
  rd_state_t      state, next_state;
  logic [LGN-1:0] raddr, next_raddr;
  bank_t          rbank, next_rbank;
  logic           rd_clear;
  logic           rd_en;
  logic [LGN:0]   rd_addr;
  logic [2*DW-1:0] rd_data;

  // NOTE: every output of this block is given a default first so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_raddr = raddr;
    next_rbank = rbank;
    rd_clear   = 1'b0;
    if (i_oce) begin
      case (state)
        S_IDLE: begin
          if (full[rbank]) begin
            next_state = S_PREFIX;
            next_raddr = CP_START;
          end
        end
        S_PREFIX: begin
          if (raddr == LAST) begin
            next_state = S_BODY;
            next_raddr = '0;
          end else begin
            next_raddr = raddr + 1'b1;
          end
        end
        S_BODY: begin
          if (raddr == LAST) begin
            rd_clear   = 1'b1;
            next_rbank = ~rbank;
            // Chain straight into the next symbol when it is already waiting.
            if (full[~rbank]) begin
              next_state = S_PREFIX;
              next_raddr = CP_START;
            end else begin
              next_state = S_IDLE;
              next_raddr = '0;
            end
          end else begin
            next_raddr = raddr + 1'b1;
          end
        end
        default: begin
          next_state = S_IDLE;
          next_raddr = '0;
        end
      endcase
    end
  end

  assign rd_en   = i_oce && (next_state != S_IDLE);
  assign rd_addr = {next_rbank, next_raddr};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      raddr <= '0;
      rbank <= '0;
    end else begin
      state <= next_state;
      raddr <= next_raddr;
      rbank <= next_rbank;
    end
  end

  // Bank flags: a set by the writer and a clear by the reader in the same
  // cycle both land; on the same bank the set wins.
  logic [1:0] full_set, full_clr;

  assign full_set = {wr_last  && (wbank == bank_t'(1)), wr_last  && (wbank == bank_t'(0))};
  assign full_clr = {rd_clear && (rbank == bank_t'(1)), rd_clear && (rbank == bank_t'(0))};

  always_ff @(posedge i_clk) begin
    if (i_reset)
      full <= '0;
    else
      full <= (full & ~full_clr) | full_set;
  end

  cpbuf #(
    .DW (DW),
    .AW (LGN + 1)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_addr),
    .i_wdata (i_sample),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_result <= '0;
      o_valid  <= 1'b0;
      o_sync   <= 1'b0;
    end else if (i_oce) begin
      if (state != S_IDLE) begin
        o_result <= rd_data;
        o_valid  <= 1'b1;
        o_sync   <= (state == S_PREFIX) && (raddr == CP_START);
      end else begin
        o_result <= '0;
        o_valid  <= 1'b0;
        o_sync   <= 1'b0;
      end
    end
  end

`ifdef CPINSERT_OVERFLOW_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_overflow <= 1'b0;
    else if (drop_frame)
      o_overflow <= 1'b1;
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule
